// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports, the memory-controller port and the
// arbiter status signals shared between mem_arbiter and its neighbours.
interface mem_arbiter_if;
  localparam int unsigned W = 32;

  // Port 0: instruction fetch
  logic         m0_read;
  logic         m0_write;
  logic [W-1:0] m0_addr;
  logic [W-1:0] m0_write_data;
  logic         m0_ack;
  logic [W-1:0] m0_read_data;

  // Port 1: data load/store
  logic         m1_read;
  logic         m1_write;
  logic [W-1:0] m1_addr;
  logic [W-1:0] m1_write_data;
  logic         m1_ack;
  logic [W-1:0] m1_read_data;

  // Memory/IO controller side
  logic         mem_read;
  logic         mem_write;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_write_data;
  logic         mem_ack;
  logic [W-1:0] mem_read_data;

  // Arbiter status
  logic         grant;
  logic         busy;

  // Arbiter view: receives requests and controller responses
  modport slave (
    input  m0_read, m0_write, m0_addr, m0_write_data,
    input  m1_read, m1_write, m1_addr, m1_write_data,
    input  mem_ack, mem_read_data,
    output m0_ack, m0_read_data, m1_ack, m1_read_data,
    output mem_read, mem_write, mem_addr, mem_write_data,
    output grant, busy
  );

  // Environment view: drives requests and controller responses
  modport master (
    output m0_read, m0_write, m0_addr, m0_write_data,
    output m1_read, m1_write, m1_addr, m1_write_data,
    output mem_ack, mem_read_data,
    input  m0_ack, m0_read_data, m1_ack, m1_read_data,
    input  mem_read, mem_write, mem_addr, mem_write_data,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory/IO controller.
// One transaction at a time: IDLE picks a port, GRANT waits for mem_ack,
// ACK returns a one-cycle completion pulse to the granted port.
module mem_arbiter (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t       state_q;
  logic         grant_q;
  logic         last_grant_q;
  logic         op_write_q;
  logic         m0_ack_q;
  logic         m1_ack_q;
  logic [W-1:0] mem_addr_q;
  logic [W-1:0] mem_wdata_q;
  logic [W-1:0] m0_rdata_q;
  logic [W-1:0] m1_rdata_q;

  logic         req0;
  logic         req1;
  logic         pick_d;
  logic         write_d;
  logic [W-1:0] addr_d;
  logic [W-1:0] wdata_d;

  // Request decode and round-robin selection; a tie goes to the port not served last
  always_comb begin
    req0    = bus.m0_read | bus.m0_write;
    req1    = bus.m1_read | bus.m1_write;
    pick_d  = (req0 & req1) ? ~last_grant_q : req1;
    write_d = pick_d ? bus.m1_write      : bus.m0_write;
    addr_d  = pick_d ? bus.m1_addr       : bus.m0_addr;
    wdata_d = pick_d ? bus.m1_write_data : bus.m0_write_data;
  end

  // Arbitration FSM with registered grant, payload and completion outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_write_q   <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            grant_q      <= pick_d;
            last_grant_q <= pick_d;
            op_write_q   <= write_d;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= wdata_d;
            state_q      <= GRANT;
          end
        end
        GRANT: begin
          // No timeout: the controller owns completion
          if (bus.mem_ack) begin
            if (grant_q) begin
              m1_ack_q   <= 1'b1;
              m1_rdata_q <= bus.mem_read_data;
            end else begin
              m0_ack_q   <= 1'b1;
              m0_rdata_q <= bus.mem_read_data;
            end
            state_q <= ACK;
          end
        end
        ACK: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Strobes drop in the same cycle as mem_ack so the controller never sees a repeat
  assign bus.mem_read  = (state_q == GRANT) & ~op_write_q & ~bus.mem_ack;
  assign bus.mem_write = (state_q == GRANT) &  op_write_q & ~bus.mem_ack;

  // Output mapping
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.m0_ack         = m0_ack_q;
  assign bus.m1_ack         = m1_ack_q;
  assign bus.m0_read_data   = m0_rdata_q;
  assign bus.m1_read_data   = m1_rdata_q;
  assign bus.grant          = grant_q;
  assign bus.busy           = (state_q == GRANT) | (state_q == ACK);

endmodule
